// File: rtl/simple_dut_core.sv
// -----------------------------------------------------------------------------
// simple_dut_core
//
// Purpose:
//   Small processing core behind the simple DUT example interface. Input beats
//   are buffered in a FIFO and handled one at a time by a three-state FSM
//   (IDLE -> [ROT] -> EMIT). Two operations are supported:
//     op 0 : add      result = data + tag (wraps mod 2^32, or saturates)
//     op 1 : rotate   result = data rotated left by tag[4:0], one bit per cycle
//   Every result is published as a 1-cycle valid pulse carrying a wrapping
//   8-bit sequence number.
//
// Configuration macro:
//   SIMPLE_DUT_SATURATE_EN  defined     -> op-0 add clamps to 32'hFFFF_FFFF on carry-out
//                           not defined -> op-0 add wraps mod 2^32
//
// Parameters:
//   FIFO_DEPTH  input FIFO entries (power of 2, >= 2)
//   SEQ_INIT    reset value of the result sequence counter
//
// Ports:
//   clk             in   1   clock, all state updates on posedge
//   rst             in   1   asynchronous reset, active-low
//   i_bitSignal1    in   1   input beat valid
//   i_bitSignal2    in   1   op select (0 = add, 1 = rotate-left)
//   i_bit32Signal1  in   32  operand data
//   i_bit8Signal2   in   8   add operand (op 0) / rotate amount in [4:0] (op 1)
//   o_bitSignal1    out  1   result valid, 1-cycle pulse
//   o_bitSignal2    out  1   sticky overflow, a beat was dropped on a full FIFO
//   o_bit32Signal1  out  32  result data, held between pulses
//   o_bit8Signal2   out  8   sequence number of the current result, held
// -----------------------------------------------------------------------------
module simple_dut_core #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SEQ_INIT   = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_bitSignal1,
    input  logic        i_bitSignal2,
    input  logic [31:0] i_bit32Signal1,
    input  logic [7:0]  i_bit8Signal2,
    output logic        o_bitSignal1,
    output logic        o_bitSignal2,
    output logic [31:0] o_bit32Signal1,
    output logic [7:0]  o_bit8Signal2
);

    localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0] ZERO_C  = (PW+1)'(0);
    localparam logic [PW:0] ONE_C   = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE_C = PW'(1);

    typedef struct packed {
        logic        op;
        logic [7:0]  tag;
        logic [31:0] data;
    } beat_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ROT  = 2'b01,
        ST_EMIT = 2'b10
    } state_t;

    // Single-step left rotation; the ROT state applies it once per cycle.
    function automatic logic [31:0] rotl1(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

    // Add path with the configurable overflow behaviour.
    function automatic logic [31:0] add_tag(input logic [31:0] a, input logic [7:0] t);
        logic [32:0] sum;
        sum = {1'b0, a} + {25'b0, t};
`ifdef SIMPLE_DUT_SATURATE_EN
        if (sum[32]) begin
            return 32'hFFFF_FFFF;
        end else begin
            return sum[31:0];
        end
`else
        return sum[31:0];
`endif
    endfunction

    // FIFO storage and bookkeeping
    beat_t         fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   count_r;

    // FSM and work registers
    state_t        state_r;
    state_t        state_s;
    logic [31:0]   acc_r;
    logic [4:0]    cnt_r;
    logic          op_r;
    logic [7:0]    tag_r;

    // Output registers
    logic          valid_r;
    logic          ovf_r;
    logic [31:0]   data_r;
    logic [7:0]    seq_r;

    // Combinational control
    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    beat_t         head_s;
    beat_t         in_beat_s;

    // FIFO status, push/pop decisions and head-of-queue view.
    always_comb begin
        fifo_empty_s = (count_r == ZERO_C);
        fifo_full_s  = (count_r >= DEPTH_C);
        head_s       = fifo_mem_r[rd_ptr_r];
        in_beat_s    = {i_bitSignal2, i_bit8Signal2, i_bit32Signal1};
        // Only IDLE pops, so a beat landing in an empty FIFO waits one edge.
        pop_s        = (state_r == ST_IDLE) && !fifo_empty_s;
        // A full FIFO still accepts when the head leaves on the same edge.
        if (i_bitSignal1 && (!fifo_full_s || pop_s)) begin
            push_s = 1'b1;
            drop_s = 1'b0;
        end else if (i_bitSignal1) begin
            push_s = 1'b0;
            drop_s = 1'b1;
        end else begin
            push_s = 1'b0;
            drop_s = 1'b0;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= '0;
            end
        end else if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= in_beat_s;
        end
    end

    // FIFO pointers and occupancy count; full/empty come from the count only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= ZERO_C;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    if (head_s.op && (head_s.tag[4:0] != 5'd0)) begin
                        state_s = ST_ROT;
                    end else begin
                        state_s = ST_EMIT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ROT: begin
                // cnt_r == 1 means this cycle performs the last rotation step.
                if (cnt_r <= 5'd1) begin
                    state_s = ST_EMIT;
                end else begin
                    state_s = ST_ROT;
                end
            end
            ST_EMIT: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Work registers: load on pop, iterate while rotating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r <= 32'h0000_0000;
            cnt_r <= 5'd0;
            op_r  <= 1'b0;
            tag_r <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        acc_r <= head_s.data;
                        cnt_r <= head_s.tag[4:0];
                        op_r  <= head_s.op;
                        tag_r <= head_s.tag;
                    end
                end
                ST_ROT: begin
                    acc_r <= rotl1(acc_r);
                    cnt_r <= cnt_r - 5'd1;
                end
                default: begin
                    acc_r <= acc_r;
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Result registers: publish on EMIT, valid is a single-cycle pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= 1'b0;
            data_r  <= 32'h0000_0000;
            seq_r   <= SEQ_INIT;
        end else if (state_r == ST_EMIT) begin
            valid_r <= 1'b1;
            data_r  <= op_r ? acc_r : add_tag(acc_r, tag_r);
            seq_r   <= seq_r + 8'd1;
        end else begin
            valid_r <= 1'b0;
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign o_bitSignal1   = valid_r;
    assign o_bitSignal2   = ovf_r;
    assign o_bit32Signal1 = data_r;
    assign o_bit8Signal2  = seq_r;

endmodule

// File: tb/tb_simple_dut_core.sv
// -----------------------------------------------------------------------------
// tb_simple_dut_core
//
// Self-checking bench for simple_dut_core. A reference model tracks the FIFO
// as a queue of accepted beats and schedules each result at the edge the
// specified latency rules give; results are computed with plain arithmetic.
// Directed scenarios are followed by a randomized traffic phase.
// -----------------------------------------------------------------------------
module tb_simple_dut_core;

    localparam int         DEPTH  = 4;
    localparam logic [7:0] SEQ_I  = 8'h00;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_op;
    logic [31:0] in_data;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ovf;
    logic [31:0] out_data;
    logic [7:0]  out_seq;

    simple_dut_core #(.FIFO_DEPTH(DEPTH), .SEQ_INIT(SEQ_I)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_bitSignal1   (in_valid),
        .i_bitSignal2   (in_op),
        .i_bit32Signal1 (in_data),
        .i_bit8Signal2  (in_tag),
        .o_bitSignal1   (out_valid),
        .o_bitSignal2   (out_ovf),
        .o_bit32Signal1 (out_data),
        .o_bit8Signal2  (out_seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [7:0]  tag;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic [31:0] d;
        logic [7:0]  s;
        int          ee;
    } res_t;

    beat_t       pend[$];
    res_t        expq[$];
    int          k;
    int          next_free;
    logic [7:0]  mseq;
    logic        movf;
    logic [31:0] last_d;
    logic [7:0]  last_s;

    int          n_vec;
    int          n_err;
    int          pulses;
    int          obs_k;
    logic [31:0] obs_d;
    logic [7:0]  obs_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, k);
        end
    endtask

    function automatic logic [31:0] ref_result(input beat_t b);
        logic [63:0] dd;
        logic [32:0] s;
        if (b.op) begin
            dd = {b.data, b.data} << b.tag[4:0];
            return dd[63:32];
        end
        s = {1'b0, b.data} + 33'(b.tag);
`ifdef SIMPLE_DUT_SATURATE_EN
        if (s > 33'h0_FFFF_FFFF) return 32'hFFFF_FFFF;
`endif
        return s[31:0];
    endfunction

    task automatic model_reset();
        pend.delete();
        expq.delete();
        next_free = 0;
        mseq      = SEQ_I;
        movf      = 1'b0;
        last_d    = 32'h0;
        last_s    = SEQ_I;
    endtask

    // Model what happens at edge k for the given input beat.
    task automatic model_edge(input logic v, input beat_t b);
        int    cnt_before;
        logic  popped;
        beat_t h;
        res_t  r;
        cnt_before = pend.size();
        popped     = 1'b0;
        if (pend.size() > 0 && k >= next_free) begin
            h      = pend.pop_front();
            popped = 1'b1;
            mseq   = mseq + 8'd1;
            r.d    = ref_result(h);
            r.s    = mseq;
            r.ee   = k + 1 + (h.op ? int'(h.tag[4:0]) : 0);
            next_free = r.ee + 1;
            expq.push_back(r);
        end
        if (v) begin
            if (cnt_before < DEPTH || popped) pend.push_back(b);
            else movf = 1'b1;
        end
    endtask

    task automatic check_outputs();
        res_t r;
        if (out_valid === 1'b1) begin
            pulses++;
            obs_k = k;
            obs_d = out_data;
            obs_s = out_seq;
        end
        if (expq.size() > 0 && expq[0].ee == k) begin
            r = expq.pop_front();
            chk("valid_pulse", 32'(out_valid), 32'h1);
            chk("result", out_data, r.d);
            chk("seq", 32'(out_seq), 32'(r.s));
            last_d = r.d;
            last_s = r.s;
        end else begin
            chk("valid_idle", 32'(out_valid), 32'h0);
            chk("data_hold", out_data, last_d);
            chk("seq_hold", 32'(out_seq), 32'(last_s));
        end
        chk("ovf", 32'(out_ovf), 32'(movf));
    endtask

    task automatic step(input logic v, input logic op, input logic [31:0] d, input logic [7:0] t);
        beat_t b;
        b.op = op; b.tag = t; b.data = d;
        in_valid = v; in_op = op; in_data = d; in_tag = t;
        model_edge(v, b);
        @(posedge clk);
        #1;
        check_outputs();
        k++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 8'h00);
    endtask

    // Hold reset for n edges with random inputs, checking reset values.
    task automatic do_reset(input int n);
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_async_valid", 32'(out_valid), 32'h0);
        chk("rst_async_seq", 32'(out_seq), 32'(SEQ_I));
        for (int i = 0; i < n; i++) begin
            in_valid = 1'($urandom); in_op = 1'($urandom);
            in_data = $urandom; in_tag = 8'($urandom);
            @(posedge clk);
            #1;
            chk("rst_valid", 32'(out_valid), 32'h0);
            chk("rst_ovf", 32'(out_ovf), 32'h0);
            chk("rst_data", out_data, 32'h0);
            chk("rst_seq", 32'(out_seq), 32'(SEQ_I));
            k++;
        end
        in_valid = 1'b0; in_op = 1'b0; in_data = 32'h0; in_tag = 8'h00;
        rst = 1'b1;
    endtask

    initial begin
        int   k0;
        logic v, op;
        logic [31:0] d;
        logic [7:0]  t;
        n_vec = 0; n_err = 0; pulses = 0; k = 0; obs_k = -1;
        obs_d = 32'h0; obs_s = 8'h0;
        rst = 1'b0;
        in_valid = 1'b0; in_op = 1'b0; in_data = 32'h0; in_tag = 8'h00;

        // 1: reset, then idle with no beats
        do_reset(5);
        pulses = 0;
        idle(10);
        chk("t1_no_pulse", 32'(pulses), 32'h0);

        // 2: add
        obs_k = -1;
        k0 = k;
        step(1'b1, 1'b0, 32'h0000_0010, 8'h05);
        idle(6);
        chk("t2_lat", 32'(obs_k - k0), 32'd2);
        chk("t2_data", obs_d, 32'h0000_0015);
        chk("t2_seq", 32'(obs_s), 32'h01);

        // 3: rotate by 4
        obs_k = -1;
        k0 = k;
        step(1'b1, 1'b1, 32'h8000_0001, 8'h04);
        idle(10);
        chk("t3_lat", 32'(obs_k - k0), 32'd6);
        chk("t3_data", obs_d, 32'h0000_0018);

        // 4: overflow with 6 back-to-back long rotates
        do_reset(2);
        pulses = 0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 32'h1234_5678 + 32'(i), 8'h1F);
        chk("t4_no_ovf_yet", 32'(out_ovf), 32'h0);
        step(1'b1, 1'b1, 32'hDEAD_BEEF, 8'h1F);
        chk("t4_ovf", 32'(out_ovf), 32'h1);
        idle(200);
        chk("t4_pulses", 32'(pulses), 32'd5);
        chk("t4_last_seq", 32'(obs_s), 32'h05);
        chk("t4_ovf_sticky", 32'(out_ovf), 32'h1);

        // 5: add near the top of the range
        do_reset(2);
        step(1'b1, 1'b0, 32'hFFFF_FFFE, 8'h05);
        idle(5);
`ifdef SIMPLE_DUT_SATURATE_EN
        chk("t5_sat", obs_d, 32'hFFFF_FFFF);
`else
        chk("t5_wrap", obs_d, 32'h0000_0003);
`endif

        // 6: reset in the middle of a rotate
        pulses = 0;
        step(1'b1, 1'b1, 32'hA5A5_0F0F, 8'h10);
        idle(5);
        do_reset(1);
        chk("t6_no_pulse", 32'(pulses), 32'h0);
        chk("t6_seq_init", 32'(out_seq), 32'(SEQ_I));
        idle(30);
        chk("t6_still_none", 32'(pulses), 32'h0);
        step(1'b1, 1'b0, 32'h0000_0100, 8'h22);
        idle(5);
        chk("t6_next_seq", 32'(obs_s), 32'h01);
        chk("t6_next_data", obs_d, 32'h0000_0122);

        // Randomized traffic with one reset in the middle
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset(3);
            v  = ($urandom_range(0, 2) != 0);
            op = 1'($urandom);
            d  = $urandom;
            t  = 8'($urandom);
            if (op && ($urandom_range(0, 3) != 0)) t[4:0] = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) d = 32'hFFFF_FFFF - 32'($urandom_range(0, 300));
            step(v, op, d, t);
        end
        idle(80);
        chk("rand_drained", 32'(expq.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
